// File: rtl/fp_mult_pipe.sv
// Three-stage pipelined floating-point multiplier: unpack/classify, significand product, normalise/round.
// Latency 3 cycles at 1 op/cycle; a stalled result freezes every stage, flush squashes all in-flight ops.
module fp_mult_pipe #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int TAG_W = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [EXP_W+MAN_W:0] in_a,
    input  logic [EXP_W+MAN_W:0] in_b,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] out_result,
    output logic [TAG_W-1:0]     out_tag,
    output logic [3:0]           out_flags
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int BIAS = (2 ** (EXP_W - 1)) - 1;
    localparam int EW2  = EXP_W + 2;
    localparam int SW   = MAN_W + 1;
    localparam int PW   = 2 * SW;
    localparam int RW   = PW - 1 - MAN_W;
    localparam logic [EW2-1:0] EXP_MAX = EW2'((2 ** EXP_W) - 1);

    typedef enum logic [1:0] {K_NUM, K_NAN, K_INF, K_ZERO} kind_e;

    logic               s1_vld_q, s2_vld_q, s3_vld_q;
    logic [TAG_W-1:0]   s1_tag_q, s2_tag_q, s3_tag_q;
    logic               s1_sign_q, s2_sign_q;
    logic [EW2-1:0]     s1_exp_q, s2_exp_q;
    logic [MAN_W-1:0]   s1_fa_q, s1_fb_q;
    kind_e              s1_kind_q, s2_kind_q;
    logic [PW-1:0]      s2_prod_q;
    logic [W-1:0]       s3_res_q;
    logic [3:0]         s3_flags_q;

    logic adv;
    assign adv      = !s3_vld_q || out_ready;
    assign in_ready = adv;

    // S1: classify operands; specials are resolved here and bypass the arithmetic path
    logic [EXP_W-1:0] ea, eb;
    logic [MAN_W-1:0] fa, fb;
    logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
    logic             s1_sign_d;
    logic [EW2-1:0]   s1_exp_d;
    kind_e            s1_kind_d;

    always_comb begin
        ea        = in_a[W-2 -: EXP_W];
        eb        = in_b[W-2 -: EXP_W];
        fa        = in_a[MAN_W-1:0];
        fb        = in_b[MAN_W-1:0];
        a_zero    = (ea == '0);
        b_zero    = (eb == '0);
        a_inf     = (&ea) && (fa == '0);
        b_inf     = (&eb) && (fb == '0);
        a_nan     = (&ea) && (fa != '0);
        b_nan     = (&eb) && (fb != '0);
        s1_sign_d = in_a[W-1] ^ in_b[W-1];
        s1_exp_d  = EW2'(ea) + EW2'(eb) - EW2'(BIAS);
        s1_kind_d = K_NUM;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
            s1_kind_d = K_NAN;
        end else if (a_inf || b_inf) begin
            s1_kind_d = K_INF;
        end else if (a_zero || b_zero) begin
            s1_kind_d = K_ZERO;
        end
    end

    logic [PW-1:0] s2_prod_d;
    assign s2_prod_d = PW'({1'b1, s1_fa_q}) * PW'({1'b1, s1_fb_q});

    // S3: the product lies in [1,4); pick the window so the leading one sits just above the kept fraction
    logic [PW-1:0]    norm;
    logic [EW2-1:0]   exp_n, exp_r;
    logic [MAN_W-1:0] keep;
    logic [RW-1:0]    rem;
    logic             rnd_up, inexact, ovf, unf;
    logic [SW-1:0]    mant_r;
    logic [W-1:0]     s3_res_d;
    logic [3:0]       s3_flags_d;

    always_comb begin
        norm    = s2_prod_q[PW-1] ? s2_prod_q : {s2_prod_q[PW-2:0], 1'b0};
        exp_n   = s2_exp_q + EW2'(s2_prod_q[PW-1]);
        keep    = norm[PW-2 -: MAN_W];
        rem     = norm[RW-1:0];
        rnd_up  = rem[RW-1] && ((|rem[RW-2:0]) || keep[0]);
        inexact = |rem;
        mant_r  = {1'b0, keep} + SW'(rnd_up);
        exp_r   = exp_n + EW2'(mant_r[MAN_W]);
        unf     = exp_r[EW2-1] || (exp_r == '0);
        ovf     = !exp_r[EW2-1] && (exp_r >= EXP_MAX);

        s3_res_d   = {s2_sign_q, exp_r[EXP_W-1:0], mant_r[MAN_W-1:0]};
        s3_flags_d = {3'b000, inexact};
        case (s2_kind_q)
            K_NAN: begin
                s3_res_d   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
                s3_flags_d = 4'b1000;
            end
            K_INF: begin
                s3_res_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                s3_flags_d = 4'b0000;
            end
            K_ZERO: begin
                s3_res_d   = {s2_sign_q, {(W-1){1'b0}}};
                s3_flags_d = 4'b0000;
            end
            default: begin
                if (ovf) begin
                    s3_res_d   = {s2_sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    s3_flags_d = 4'b0101;
                end else if (unf) begin
                    s3_res_d   = {s2_sign_q, {(W-1){1'b0}}};
                    s3_flags_d = 4'b0011;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s3_vld_q <= 1'b0;
        end else if (flush) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s3_vld_q <= 1'b0;
        end else if (adv) begin
            s1_vld_q <= in_valid;
            s2_vld_q <= s1_vld_q;
            s3_vld_q <= s2_vld_q;
        end
    end

    // Payload only moves behind a valid bit, so the output fields hold their last result across bubbles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_tag_q   <= '0;
            s1_sign_q  <= 1'b0;
            s1_exp_q   <= '0;
            s1_fa_q    <= '0;
            s1_fb_q    <= '0;
            s1_kind_q  <= K_NUM;
            s2_tag_q   <= '0;
            s2_sign_q  <= 1'b0;
            s2_exp_q   <= '0;
            s2_prod_q  <= '0;
            s2_kind_q  <= K_NUM;
            s3_tag_q   <= '0;
            s3_res_q   <= '0;
            s3_flags_q <= '0;
        end else if (adv && !flush) begin
            if (in_valid) begin
                s1_tag_q  <= in_tag;
                s1_sign_q <= s1_sign_d;
                s1_exp_q  <= s1_exp_d;
                s1_fa_q   <= fa;
                s1_fb_q   <= fb;
                s1_kind_q <= s1_kind_d;
            end
            if (s1_vld_q) begin
                s2_tag_q  <= s1_tag_q;
                s2_sign_q <= s1_sign_q;
                s2_exp_q  <= s1_exp_q;
                s2_prod_q <= s2_prod_d;
                s2_kind_q <= s1_kind_q;
            end
            if (s2_vld_q) begin
                s3_tag_q   <= s2_tag_q;
                s3_res_q   <= s3_res_d;
                s3_flags_q <= s3_flags_d;
            end
        end
    end

    assign out_valid  = s3_vld_q;
    assign out_result = s3_res_q;
    assign out_tag    = s3_tag_q;
    assign out_flags  = s3_flags_q;
endmodule

// File: tb/tb_fp_mult_pipe.sv
// Bench for fp_mult_pipe: directed vectors, stall/flush/reset scenarios and a randomized run
// scored against a real-arithmetic reference model.
module tb_fp_mult_pipe;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_a, in_b, out_result;
    logic [3:0]  in_tag, out_tag, out_flags;

    int total = 0;
    int bad   = 0;
    logic [39:0] exp_q[$];
    logic [3:0]  seen_tags[$];
    bit          rnd_ready = 1'b0;
    logic        stall_prev = 1'b0;
    logic [39:0] held;

    fp_mult_pipe #(.EXP_W(8), .MAN_W(23), .TAG_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag), .out_flags(out_flags)
    );

    task automatic check(input string name, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // Reference: the product of two single-precision significands is exact in double precision,
    // so multiply as reals and round the double's 52-bit fraction down to 23 bits.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b);
        logic [7:0]  ea, eb;
        logic [22:0] fa, fb;
        logic        sgn, an, bn, ai, bi, az, bz, ru;
        real         ra, rb, p;
        logic [63:0] pb;
        logic [22:0] kp;
        logic [28:0] rm;
        logic [23:0] m;
        int          be;
        ea = a[30:23]; eb = b[30:23]; fa = a[22:0]; fb = b[22:0];
        sgn = a[31] ^ b[31];
        an = (ea == 8'hFF) && (fa != 0); bn = (eb == 8'hFF) && (fb != 0);
        ai = (ea == 8'hFF) && (fa == 0); bi = (eb == 8'hFF) && (fb == 0);
        az = (ea == 0); bz = (eb == 0);
        if (an || bn || (ai && bz) || (bi && az)) return {4'b1000, 32'h7FC00000};
        if (ai || bi) return {4'b0000, sgn, 8'hFF, 23'd0};
        if (az || bz) return {4'b0000, sgn, 31'd0};
        ra = $bitstoreal({1'b0, 11'(ea) + 11'd896, fa, 29'd0});
        rb = $bitstoreal({1'b0, 11'(eb) + 11'd896, fb, 29'd0});
        p  = ra * rb;
        pb = $realtobits(p);
        kp = pb[51:29];
        rm = pb[28:0];
        ru = rm[28] && ((rm[27:0] != 0) || kp[0]);
        m  = {1'b0, kp} + 24'(ru);
        be = int'(pb[62:52]) - 1023 + 127 + int'(m[23]);
        if (be >= 255) return {4'b0101, sgn, 8'hFF, 23'd0};
        if (be <= 0) return {4'b0011, sgn, 31'd0};
        return {3'b000, (rm != 0), sgn, 8'(be), m[22:0]};
    endfunction

    function automatic logic [31:0] rnd_op();
        logic [7:0]  e;
        logic [22:0] f;
        case ($urandom_range(0, 9))
            0:       e = 8'd0;
            1:       e = 8'hFF;
            2:       e = 8'($urandom_range(0, 255));
            default: e = 8'($urandom_range(64, 190));
        endcase
        f = ($urandom_range(0, 7) == 0) ? 23'd0 : 23'($urandom);
        return {1'($urandom), e, f};
    endfunction

    // Scoreboard: values seen on the falling edge are what the next rising edge transfers
    always @(negedge clk) begin
        logic [39:0] e;
        if (!rst_n) begin
            exp_q.delete();
            stall_prev = 1'b0;
        end else begin
            if (stall_prev && out_valid)
                check("stall_hold", {out_tag, out_flags, out_result}, held);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_out_valid", out_valid, 1'b0);
                end else begin
                    e = exp_q.pop_front();
                    check("pipe_out", {out_tag, out_flags, out_result}, e);
                end
                seen_tags.push_back(out_tag);
            end
            stall_prev = out_valid && !out_ready;
            held = {out_tag, out_flags, out_result};
            if (flush) exp_q.delete();
            else if (in_valid && in_ready) exp_q.push_back({in_tag, model(in_a, in_b)});
        end
    end

    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
        int   g = 0;
        logic ok;
        in_a = a; in_b = b; in_tag = tag; in_valid = 1'b1;
        do begin
            if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
            #1;
            ok = in_ready;
            @(posedge clk); #1;
            g++;
        end while (!ok && g < 200);
        in_valid = 1'b0;
        if (!ok) check("send_timeout", ok, 1'b1);
    endtask

    task automatic run_one(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] tag, input logic [31:0] eres, input logic [3:0] eflg);
        int lat = 1;
        send(a, b, tag);
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({name, "_latency"}, lat, 3);
        check({name, "_result"}, out_result, eres);
        check({name, "_tag"}, out_tag, tag);
        check({name, "_flags"}, out_flags, eflg);
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int g = 0;
        out_ready = 1'b1;
        while ((exp_q.size() != 0 || out_valid) && g < 500) begin
            @(posedge clk); #1;
            g++;
        end
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_tag = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_result", out_result, 32'h0);
        check("rst_out_tag", out_tag, 4'h0);
        check("rst_out_flags", out_flags, 4'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("in_ready_after_reset", in_ready, 1'b1);

        run_one("basic", 32'h411C0000, 32'h3F100000, 4'd5, 32'h40AF8000, 4'b0000);

        // back-to-back issue emerges on consecutive cycles
        in_valid = 1'b1; in_a = 32'h40800000; in_b = 32'hBE800000; in_tag = 4'd2;
        @(posedge clk); #1;
        in_a = 32'hC0800000; in_b = 32'hC0800000; in_tag = 4'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        check("b2b_first_valid", out_valid, 1'b1);
        check("b2b_first_tag", out_tag, 4'd2);
        check("b2b_first_result", out_result, 32'hBF800000);
        @(posedge clk); #1;
        check("b2b_second_valid", out_valid, 1'b1);
        check("b2b_second_tag", out_tag, 4'd3);
        check("b2b_second_result", out_result, 32'h41800000);
        @(posedge clk); #1;

        run_one("round_up", 32'h3F800001, 32'h3F800001, 4'd6, 32'h3F800002, 4'b0001);
        run_one("one_x_one", 32'h3F800000, 32'h3F800000, 4'd7, 32'h3F800000, 4'b0000);
        run_one("inf_x_zero", 32'h7F800000, 32'h00000000, 4'd8, 32'h7FC00000, 4'b1000);
        run_one("nan_x_inf", 32'h7FFFFFFF, 32'h7F800000, 4'd9, 32'h7FC00000, 4'b1000);
        run_one("zero_x_neg", 32'h00000000, 32'hD20EE979, 4'd10, 32'h80000000, 4'b0000);
        run_one("overflow", 32'h7F000000, 32'h7F000000, 4'd11, 32'h7F800000, 4'b0101);
        run_one("underflow", 32'h00800000, 32'h00800000, 4'd12, 32'h00000000, 4'b0011);

        // backpressure: three ops fill the pipe, the fourth waits
        seen_tags.delete();
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) send(32'h40000000 + (32'(i) << 20), 32'h3FC00000, 4'(i));
        check("bp_in_ready_low", in_ready, 1'b0);
        in_valid = 1'b1; in_a = 32'h40400000; in_b = 32'h3FC00000; in_tag = 4'd4;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("bp_stall_in_ready", in_ready, 1'b0);
            check("bp_stall_tag", out_tag, 4'd1);
        end
        out_ready = 1'b1;
        send(32'h40400000, 32'h3FC00000, 4'd4);
        send(32'h40500000, 32'h3FC00000, 4'd5);
        drain();
        check("bp_count", seen_tags.size(), 5);
        for (int i = 0; i < seen_tags.size() && i < 5; i++) check("bp_order", seen_tags[i], 4'(i + 1));

        // flush with three ops in flight
        out_ready = 1'b0;
        for (int i = 6; i <= 8; i++) send(32'h3F800000 + (32'(i) << 16), 32'h40000000, 4'(i));
        flush = 1'b1; in_valid = 1'b1; in_a = 32'h3F800000; in_b = 32'h3F800000; in_tag = 4'd15;
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        check("flush_out_valid", out_valid, 1'b0);
        run_one("after_flush", 32'h40400000, 32'h40400000, 4'd13, 32'h41100000, 4'b0000);

        // asynchronous reset mid-cycle with three ops in flight
        out_ready = 1'b0;
        for (int i = 1; i <= 3; i++) send(32'h40000000, 32'h40000000 + (32'(i) << 20), 4'(i));
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", out_valid, 1'b0);
        check("arst_out_result", out_result, 32'h0);
        check("arst_out_tag", out_tag, 4'h0);
        check("arst_out_flags", out_flags, 4'h0);
        @(posedge clk); #1;
        rst_n = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("arst_no_output", out_valid, 1'b0);
        end
        check("arst_in_ready", in_ready, 1'b1);
        run_one("after_reset", 32'hC0000000, 32'h40A00000, 4'd14, 32'hC1200000, 4'b0000);

        // randomized traffic with random output backpressure
        rnd_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                out_ready = ($urandom_range(0, 3) != 0);
                @(posedge clk); #1;
            end
            send(rnd_op(), rnd_op(), 4'($urandom));
        end
        rnd_ready = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog expired before test completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fp_mult_pipe.md
Name: fp_mult_pipe

Overview:
- Pipelined, parametrised IEEE-754-style floating-point multiplier. It replaces the single-cycle combinational single-precision multiplier in the FMUL functional unit.
- It accepts one operation per cycle from the FMUL reservation station with a valid/ready handshake.
- Each operation carries a reservation-station tag through to the common-data-bus arbiter.
- It applies round-to-nearest-even and reports exception flags.

Parameters:
- EXP_W, 8, exponent field width in bits.
- MAN_W, 23, stored mantissa (fraction) width in bits.
- TAG_W, 4, width of the reservation-station tag carried with each operation.
- Derived, not overridable: W = 1+EXP_W+MAN_W (32 at defaults); BIAS = 2^(EXP_W-1)-1.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- flush  in  1  synchronous squash of all in-flight operations.
- in_valid  in  1  operands and tag valid this cycle.
- in_ready  out  1  unit accepts the operation this cycle.
- in_a  in  W  operand A, format {sign, exp, frac}.
- in_b  in  W  operand B.
- in_tag  in  TAG_W  reservation-station tag.
- out_valid  out  1  result valid.
- out_ready  in  1  CDB arbiter accepts the result.
- out_result  out  W  product.
- out_tag  out  TAG_W  tag of the result.
- out_flags  out  4  {invalid, overflow, underflow, inexact}.

Behaviour:
- Reset and flush:
  - Reset (rst_n=0, asynchronous) clears all stage valid bits and drives out_valid=0, out_result=0, out_tag=0, out_flags=0.
  - in_ready is 1 from the first cycle after reset deassertion.
  - Reset mid-operation discards every in-flight operation; nothing is emitted afterwards.
- Pipeline structure: 3 registered stages, S1 to S3; S3 drives the outputs.
  - adv = !S3.valid || out_ready; in_ready = adv.
  - When adv=1, all stages shift by one and S1 captures the input if in_valid.
  - When adv=0, every stage holds, and outputs stay stable while out_valid=1.
  - Bubbles are not compressed.
  - Latency is 3 cycles from acceptance to out_valid when there is no stall.
  - Throughput is 1 op/cycle. Operations leave in acceptance order.
- Handshake rules:
  - A transfer occurs on a cycle with in_valid&&in_ready, or out_valid&&out_ready.
  - When the pipeline is full and out_ready=1 on the same cycle a new input arrives, that input is still accepted.
- flush=1:
  - All valid bits clear at the next edge; the input on that cycle is not accepted.
  - flush takes priority over adv.
- S1 (unpack and classify):
  - Decode zero (exp=0, all fractions; denormals are flushed to zero), inf, and NaN for each operand.
  - Sign = a.sign XOR b.sign.
  - Exponent sum = ea+eb-BIAS, held with EXP_W+2 signed bits.
- S2 (significand product):
  - (1.fa) x (1.fb) gives a 2*(MAN_W+1)-bit product.
- S3 (normalise and round):
  - If product MSB=1, shift right 1 and increment the exponent.
  - Guard, round and sticky bits come from the discarded bits; apply round-to-nearest-even.
  - A mantissa carry-out from rounding renormalises and increments the exponent.
  - inexact is set when any discarded bit is nonzero.
- Final exponent range:
  - Exponent >= 2^EXP_W-1 gives signed inf, with overflow=1 and inexact=1.
  - Exponent <= 0 gives signed zero, with underflow=1 and inexact=1.
- Special cases, decided in S1 and carried through; these override the arithmetic path:
  - NaN x any, or inf x 0, gives canonical qNaN {0, all-ones exp, frac MSB=1, rest 0} with invalid=1.
  - inf x nonzero finite, or inf x inf, gives signed inf with no flags.
  - 0 x finite gives signed zero with no flags.
- out_flags is valid only with out_valid; it is held at its last value otherwise.

Test Plan:
1. Basic product and latency: accept in_a=0x411C0000 (9.75), in_b=0x3F100000 (0.5625), tag=5 at cycle 0 -> out_valid at cycle 3, out_result=0x40AF8000, out_tag=5, flags=0000.
2. Signs and back-to-back issue:
   - 0x40800000 x 0xBE800000 -> 0xBF800000.
   - 0xC0800000 x 0xC0800000 -> 0x41800000.
   - Issued on consecutive cycles, these appear on consecutive cycles in order.
3. Rounding: 0x3F800001 x 0x3F800001 -> 0x3F800002 with inexact=1; 0x3F800000 x 0x3F800000 -> 0x3F800000 with flags=0000.
4. Specials and range:
   - 0x7F800000 x 0 -> 0x7FC00000, invalid=1.
   - 0x7FFFFFFF x 0x7F800000 -> 0x7FC00000, invalid=1.
   - 0 x 0xD20EE979 -> 0x80000000, flags=0000.
   - 0x7F000000 x 0x7F000000 -> 0x7F800000, overflow=1 and inexact=1.
   - 0x00800000 x 0x00800000 -> 0x00000000, underflow=1 and inexact=1.
5. Backpressure:
   - Setup: hold out_ready=0 and drive 5 back-to-back ops with tags 1 to 5.
   - While stalled: in_ready drops after 3 ops are held (S3 full, at most one op per stage), and outputs are stable throughout.
   - After raising out_ready: tags 1 to 5 emerge in order with no loss or duplication.
6. Flush and reset:
   - With 3 ops in flight, pulse flush for 1 cycle -> no out_valid for those ops, and an op accepted the next cycle emerges 3 cycles later.
   - Repeat with rst_n pulsed low asynchronously mid-cycle -> outputs go to 0 immediately.
